// File: rtl/id_pkg.sv
// id_pkg: shared state encoding and character codes for the identifier generator and recogniser
// Build option: ID_STR_GEN_TERM_EN adds the TERM state.
package id_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LETTERS,
    S_DIGITS,
`ifdef ID_STR_GEN_TERM_EN
    S_TERM,
`endif
    S_DONE
  } state_t;
  localparam logic [7:0] CHAR_A = 8'h61;
  localparam logic [7:0] CHAR_0 = 8'h30;
  localparam logic [7:0] CHAR_NUL = 8'h00;
  localparam int LETTER_MOD = 26;
  localparam int DIGIT_MOD = 10;
endpackage

// File: rtl/id_mod_ctr.sv
// id_mod_ctr: modulo-N counter with load, enable and wrap to zero after N-1
// Ports: i_clk, i_rst_n (sync, active-low), i_load/i_seed (load wins over enable),
//        i_en (advance), o_nxt (value the counter takes on its next advance).
module id_mod_ctr #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_seed,
  input  logic         i_en,
  output logic [W-1:0] o_nxt
);
  logic [W-1:0] r_q;
  // The post-increment value is exported so the owner can register the
  // matching character on the same edge the counter advances.
  always_comb o_nxt = (r_q == W'(N - 1)) ? '0 : r_q + 1'b1;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_q <= '0;
    else if (i_load) r_q <= i_seed;
    else if (i_en) r_q <= o_nxt;
  end
endmodule

// File: rtl/id_str_gen.sv
// id_str_gen: emits letters, digits and an optional terminator as a valid/ready byte stream
// Ports: i_clk, i_rst_n (sync, active-low), i_start, i_n_letters (1..15), i_n_digits (0..15),
//        i_first (0..25), i_ready; o_char, o_valid, o_busy, o_done (pulse), o_err (pulse).
// Build option: ID_STR_GEN_TERM_EN appends TERM_CHAR to every identifier.
module id_str_gen
  import id_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h2F
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_n_letters,
  input  logic [3:0] i_n_digits,
  input  logic [4:0] i_first,
  input  logic       i_ready,
  output logic [7:0] o_char,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);
`ifdef ID_STR_GEN_TERM_EN
  localparam bit HAS_TERM = 1'b1;
  localparam state_t END_STATE = S_TERM;
`else
  localparam bit HAS_TERM = 1'b0;
  localparam state_t END_STATE = S_DONE;
`endif
  state_t r_state;
  logic [3:0] r_cnt, r_nl, r_nd;
  logic [4:0] w_l_nxt;
  logic [3:0] w_d_nxt;
  logic w_bad, w_accept, w_xfer;
  always_comb w_bad = (i_n_letters == 4'd0) || (i_first > 5'd25);
  always_comb w_accept = (r_state == S_IDLE) && i_start && !w_bad;
  always_comb w_xfer = o_valid && i_ready;
  id_mod_ctr #(.N(LETTER_MOD), .W(5)) u_letter (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(w_accept), .i_seed(i_first),
    .i_en(w_xfer && r_state == S_LETTERS), .o_nxt(w_l_nxt)
  );
  id_mod_ctr #(.N(DIGIT_MOD), .W(4)) u_digit (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(w_accept), .i_seed(4'd0),
    .i_en(w_xfer && r_state == S_DIGITS), .o_nxt(w_d_nxt)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_nl <= '0;
      r_nd <= '0;
      o_char <= CHAR_NUL;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          if (w_bad) o_err <= 1'b1;
          else begin
            r_state <= S_LETTERS;
            r_nl <= i_n_letters;
            r_nd <= i_n_digits;
            r_cnt <= '0;
            o_char <= CHAR_A + {3'b0, i_first};
            o_valid <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        S_LETTERS: if (w_xfer) begin
          if (r_cnt != r_nl - 4'd1) begin
            r_cnt <= r_cnt + 4'd1;
            o_char <= CHAR_A + {3'b0, w_l_nxt};
          end else if (r_nd != 4'd0) begin
            r_state <= S_DIGITS;
            r_cnt <= '0;
            o_char <= CHAR_0;
          end else begin
            r_state <= END_STATE;
            o_char <= HAS_TERM ? TERM_CHAR : CHAR_NUL;
            o_valid <= HAS_TERM;
            o_done <= !HAS_TERM;
          end
        end
        S_DIGITS: if (w_xfer) begin
          if (r_cnt != r_nd - 4'd1) begin
            r_cnt <= r_cnt + 4'd1;
            o_char <= CHAR_0 + {4'b0, w_d_nxt};
          end else begin
            r_state <= END_STATE;
            o_char <= HAS_TERM ? TERM_CHAR : CHAR_NUL;
            o_valid <= HAS_TERM;
            o_done <= !HAS_TERM;
          end
        end
`ifdef ID_STR_GEN_TERM_EN
        S_TERM: if (w_xfer) begin
          r_state <= S_DONE;
          o_char <= CHAR_NUL;
          o_valid <= 1'b0;
          o_done <= 1'b1;
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
